// File: rtl/ddr_zqcal_pkg.sv
// rtl/ddr_zqcal_pkg.sv - shared types and constants for the ZQ calibration controller
package ddr_zqcal_pkg;

    localparam int ZQCAL_SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PD_SET  = 3'd1,
        ST_PD_WAIT = 3'd2,
        ST_PD_SAMP = 3'd3,
        ST_PU_SET  = 3'd4,
        ST_PU_WAIT = 3'd5,
        ST_PU_SAMP = 3'd6,
        ST_DONE    = 3'd7
    } zqcal_state_t;

    typedef enum logic {
        PHASE_PD = 1'b0,
        PHASE_PU = 1'b1
    } zqcal_phase_t;

endpackage

// File: rtl/ddr_zqcal_demet.sv
// rtl/ddr_zqcal_demet.sv - multi-flop demet synchronizer for a single asynchronous bit
module ddr_zqcal_demet #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], i_d};
        end
    end

    assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/ddr_zqcal_sar.sv
// rtl/ddr_zqcal_sar.sv - one SAR search engine (trial code, bit index, keep/clear decision)
module ddr_zqcal_sar #(
    parameter int CODE_W = 6
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_set,
    input  logic              i_step,
    input  logic              i_keep,
    output logic [CODE_W-1:0] o_trial,
    output logic [CODE_W-1:0] o_decided,
    output logic              o_last
);

    localparam int IDX_W = $clog2(CODE_W);

    logic [CODE_W-1:0] trial_q, trial_d;
    logic [CODE_W-1:0] bit_mask;
    logic [IDX_W-1:0]  idx_q, idx_d;

    assign bit_mask  = CODE_W'(1) << idx_q;
    // Trial value after the current bit's keep/clear verdict; lets the caller latch the final code
    assign o_decided = i_keep ? trial_q : (trial_q & ~bit_mask);
    assign o_trial   = trial_q;
    assign o_last    = (idx_q == '0);

    always_comb begin
        trial_d = trial_q;
        idx_d   = idx_q;
        if (i_clr) begin
            trial_d = '0;
            idx_d   = IDX_W'(CODE_W - 1);
        end else if (i_set) begin
            trial_d = trial_q | bit_mask;
        end else if (i_step) begin
            trial_d = o_decided;
            if (idx_q != '0) begin
                idx_d = idx_q - IDX_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            trial_q <= '0;
            idx_q   <= IDX_W'(CODE_W - 1);
        end else begin
            trial_q <= trial_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/ddr_zqcal_ctrl.sv
// rtl/ddr_zqcal_ctrl.sv - ZQ calibration FSM: NCAL then PCAL SAR search; DDR_ZQCAL_AVG_EN selects 3-sample majority voting
module ddr_zqcal_ctrl
    import ddr_zqcal_pkg::*;
#(
    parameter int CODE_W = 6,
    parameter int CNT_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [CNT_W-1:0]  i_settle_cnt,
    input  logic              i_zqcal_comp,
    output logic              o_cal_ena,
    output logic              o_pd_sel,
    output logic [CODE_W-1:0] o_ncal,
    output logic [CODE_W-1:0] o_pcal,
    output logic              o_busy,
    output logic              o_done,
    output logic [1:0]        o_sat
);

    zqcal_state_t      state_q, state_d;
    zqcal_phase_t      phase;
    logic [CNT_W:0]    cnt_q, cnt_d;
    logic [CODE_W-1:0] ncal_q, ncal_d;
    logic [CODE_W-1:0] pcal_q, pcal_d;
    logic [1:0]        sat_q, sat_d;
    logic              comp_sync;
    logic              keep;
    logic              fire;
    logic              sar_clr, sar_set, sar_step, sar_last;
    logic [CODE_W-1:0] sar_trial, sar_decided;
    logic              in_pd, in_pu;

    function automatic logic is_sat(input logic [CODE_W-1:0] code);
        return (code == '0) || (&code);
    endfunction

    ddr_zqcal_demet #(
        .STAGES (ZQCAL_SYNC_STAGES)
    ) u_demet (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_zqcal_comp),
        .o_q     (comp_sync)
    );

    ddr_zqcal_sar #(
        .CODE_W (CODE_W)
    ) u_sar (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clr     (sar_clr),
        .i_set     (sar_set),
        .i_step    (sar_step),
        .i_keep    (keep),
        .o_trial   (sar_trial),
        .o_decided (sar_decided),
        .o_last    (sar_last)
    );

`ifdef DDR_ZQCAL_AVG_EN
    logic [1:0] vote_q, vote_d;
    logic [1:0] sidx_q, sidx_d;

    // Third sample of the window decides: majority of the two stored votes plus the current one
    always_comb begin
        vote_d = '0;
        sidx_d = '0;
        fire   = 1'b0;
        keep   = (({1'b0, vote_q} + {2'b00, comp_sync}) >= 3'd2);
        if ((state_q == ST_PD_SAMP || state_q == ST_PU_SAMP) && !i_abort) begin
            if (sidx_q == 2'd2) begin
                fire = 1'b1;
            end else begin
                vote_d = vote_q + {1'b0, comp_sync};
                sidx_d = sidx_q + 2'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vote_q <= '0;
            sidx_q <= '0;
        end else begin
            vote_q <= vote_d;
            sidx_q <= sidx_d;
        end
    end
`else
    assign fire = 1'b1;
    assign keep = comp_sync;
`endif

    assign in_pd = (state_q == ST_PD_SET) || (state_q == ST_PD_WAIT) || (state_q == ST_PD_SAMP);
    assign in_pu = (state_q == ST_PU_SET) || (state_q == ST_PU_WAIT) || (state_q == ST_PU_SAMP);
    assign phase = in_pd ? PHASE_PD : PHASE_PU;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ncal_d   = ncal_q;
        pcal_d   = pcal_q;
        sat_d    = sat_q;
        sar_clr  = 1'b0;
        sar_set  = 1'b0;
        sar_step = 1'b0;
        if (state_q != ST_IDLE && i_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        state_d = ST_PD_SET;
                        sar_clr = 1'b1;
                        sat_d   = 2'b00;
                    end
                end
                ST_PD_SET, ST_PU_SET: begin
                    sar_set = 1'b1;
                    // Two extra wait cycles absorb the comparator synchronizer latency
                    cnt_d   = {1'b0, i_settle_cnt} + (CNT_W+1)'(1);
                    state_d = (phase == PHASE_PD) ? ST_PD_WAIT : ST_PU_WAIT;
                end
                ST_PD_WAIT, ST_PU_WAIT: begin
                    if (cnt_q == '0) begin
                        state_d = (phase == PHASE_PD) ? ST_PD_SAMP : ST_PU_SAMP;
                    end else begin
                        cnt_d = cnt_q - (CNT_W+1)'(1);
                    end
                end
                ST_PD_SAMP, ST_PU_SAMP: begin
                    if (fire) begin
                        if (!sar_last) begin
                            sar_step = 1'b1;
                            state_d  = (phase == PHASE_PD) ? ST_PD_SET : ST_PU_SET;
                        end else if (phase == PHASE_PD) begin
                            ncal_d  = sar_decided;
                            sar_clr = 1'b1;
                            state_d = ST_PU_SET;
                        end else begin
                            pcal_d  = sar_decided;
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    sat_d   = {is_sat(pcal_q), is_sat(ncal_q)};
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ncal_q  <= '0;
            pcal_q  <= '0;
            sat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ncal_q  <= ncal_d;
            pcal_q  <= pcal_d;
            sat_q   <= sat_d;
        end
    end

    assign o_cal_ena = (state_q != ST_IDLE);
    assign o_busy    = (state_q != ST_IDLE);
    assign o_pd_sel  = in_pd;
    assign o_ncal    = in_pd ? sar_trial : ncal_q;
    assign o_pcal    = in_pu ? sar_trial : pcal_q;
    assign o_done    = (state_q == ST_DONE);
    assign o_sat     = sat_q;

endmodule

// File: tb/tb_ddr_zqcal_ctrl.sv
// tb/tb_ddr_zqcal_ctrl.sv - directed bench for ddr_zqcal_ctrl; glitch test active when DDR_ZQCAL_AVG_EN is defined
module tb_ddr_zqcal_ctrl;

`ifdef DDR_ZQCAL_AVG_EN
    localparam int SAMP_EXTRA = 2;
`else
    localparam int SAMP_EXTRA = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] settle;
    logic       comp;
    logic       cal_ena, pd_sel, busy, done;
    logic [5:0] ncal, pcal;
    logic [1:0] sat;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int tgt_n = 0;
    int tgt_p = 0;
    bit glitch_en = 1'b0;
    logic glitch;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Comparator model: trial code at or below target keeps the bit
    assign glitch = glitch_en && (((cyc - start_cyc) % (8 + SAMP_EXTRA)) == 8);
    assign comp = (pd_sel ? (int'(ncal) <= tgt_n) : (int'(pcal) <= tgt_p)) && !glitch;

    ddr_zqcal_ctrl #(.CODE_W(6), .CNT_W(8)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_abort      (abort),
        .i_settle_cnt (settle),
        .i_zqcal_comp (comp),
        .o_cal_ena    (cal_ena),
        .o_pd_sel     (pd_sel),
        .o_ncal       (ncal),
        .o_pcal       (pcal),
        .o_busy       (busy),
        .o_done       (done),
        .o_sat        (sat)
    );

    function automatic int exp_done(input int s);
        return 2 * 6 * (s + 4 + SAMP_EXTRA) + 1;
    endfunction

    // Drives one run; cycle n counts edges after the edge where i_start is launched
    task automatic run(input int tn, input int tp, input int s, input int st_a, input int st_b,
                       input int ab, input bit gl,
                       output int done_at, output int done_cnt, output logic busy1, output logic busy_end);
        tgt_n = tn;
        tgt_p = tp;
        settle = 8'(s);
        glitch_en = gl;
        done_at = -1;
        done_cnt = 0;
        busy1 = 1'b0;
        busy_end = 1'b1;
        @(posedge clk); #1;
        start_cyc = cyc;
        start = 1'b1;
        for (int n = 1; n < 400; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            abort = 1'b0;
            if (n == 1) busy1 = busy;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = n;
            end
            if (ab > 0 && n == ab) busy_end = busy;
            if (n + 1 == st_a || n + 1 == st_b) start = 1'b1;
            if (ab > 0 && n + 1 == ab) abort = 1'b1;
            if (ab == 0 && done_at >= 0 && n == done_at + 1) begin
                busy_end = busy;
                break;
            end
            if (ab > 0 && n == ab + 4) break;
        end
        glitch_en = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (cal_ena !== 1'b0) begin bad++; $display("FAIL reset_cal_ena got=%b want=0", cal_ena); end
        total++; if (ncal !== 6'd0 || pcal !== 6'd0) begin bad++; $display("FAIL reset_codes got=%0d/%0d want=0/0", ncal, pcal); end
        total++; if (sat !== 2'b00 || done !== 1'b0 || pd_sel !== 1'b0) begin bad++; $display("FAIL reset_misc sat=%b done=%b pd=%b want=0", sat, done, pd_sel); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        int d, c; logic b1, be;
        run(37, 20, 4, 0, 0, 0, 1'b0, d, c, b1, be);
        total++; if (b1 !== 1'b1) begin bad++; $display("FAIL basic_busy_rise got=%b want=1", b1); end
        total++; if (d !== exp_done(4)) begin bad++; $display("FAIL basic_done_cycle got=%0d want=%0d", d, exp_done(4)); end
        total++; if (c !== 1) begin bad++; $display("FAIL basic_done_count got=%0d want=1", c); end
        total++; if (ncal !== 6'd37) begin bad++; $display("FAIL basic_ncal got=%0d want=37", ncal); end
        total++; if (pcal !== 6'd20) begin bad++; $display("FAIL basic_pcal got=%0d want=20", pcal); end
        total++; if (sat !== 2'b00) begin bad++; $display("FAIL basic_sat got=%b want=00", sat); end
        total++; if (be !== 1'b0 || cal_ena !== 1'b0) begin bad++; $display("FAIL basic_idle busy=%b ena=%b want=0", be, cal_ena); end
    endtask

    task automatic test_settle_zero;
        int d, c; logic b1, be;
        run(5, 58, 0, 0, 0, 0, 1'b0, d, c, b1, be);
        total++; if (d !== exp_done(0)) begin bad++; $display("FAIL s0_done_cycle got=%0d want=%0d", d, exp_done(0)); end
        total++; if (ncal !== 6'd5 || pcal !== 6'd58) begin bad++; $display("FAIL s0_codes got=%0d/%0d want=5/58", ncal, pcal); end
    endtask

    task automatic test_saturation;
        int d, c; logic b1, be;
        run(63, 0, 4, 0, 0, 0, 1'b0, d, c, b1, be);
        total++; if (ncal !== 6'd63) begin bad++; $display("FAIL sat_ncal got=%0d want=63", ncal); end
        total++; if (pcal !== 6'd0) begin bad++; $display("FAIL sat_pcal got=%0d want=0", pcal); end
        total++; if (sat !== 2'b11) begin bad++; $display("FAIL sat_flags got=%b want=11", sat); end
    endtask

    task automatic test_abort;
        int d, c; logic b1, be;
        int pb;
        pb = 4 + 4 + SAMP_EXTRA;
        run(37, 20, 4, 0, 0, 0, 1'b0, d, c, b1, be);
        run(10, 50, 4, 0, 0, 1 + 8 * pb + 2, 1'b0, d, c, b1, be);
        total++; if (be !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", be); end
        total++; if (c !== 0) begin bad++; $display("FAIL abort_done_count got=%0d want=0", c); end
        total++; if (ncal !== 6'd10) begin bad++; $display("FAIL abort_ncal got=%0d want=10", ncal); end
        total++; if (pcal !== 6'd20) begin bad++; $display("FAIL abort_pcal got=%0d want=20", pcal); end
        total++; if (sat !== 2'b00) begin bad++; $display("FAIL abort_sat got=%b want=00", sat); end
    endtask

    task automatic test_start_ignored;
        int d, c; logic b1, be;
        run(37, 20, 4, 5, 40, 0, 1'b0, d, c, b1, be);
        total++; if (d !== exp_done(4) || c !== 1) begin bad++; $display("FAIL ign_done got=%0d x%0d want=%0d x1", d, c, exp_done(4)); end
        total++; if (ncal !== 6'd37 || pcal !== 6'd20) begin bad++; $display("FAIL ign_codes got=%0d/%0d want=37/20", ncal, pcal); end
    endtask

    task automatic test_reset_mid;
        tgt_n = 37;
        tgt_p = 20;
        settle = 8'd4;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || cal_ena !== 1'b0 || pd_sel !== 1'b0) begin bad++; $display("FAIL midrst_ctrl busy=%b ena=%b pd=%b want=0", busy, cal_ena, pd_sel); end
        total++; if (ncal !== 6'd0 || pcal !== 6'd0) begin bad++; $display("FAIL midrst_codes got=%0d/%0d want=0/0", ncal, pcal); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL midrst_idle busy=%b done=%b want=0", busy, done); end
    endtask

`ifdef DDR_ZQCAL_AVG_EN
    task automatic test_avg_glitch;
        int d, c; logic b1, be;
        run(37, 20, 4, 0, 0, 0, 1'b1, d, c, b1, be);
        total++; if (d !== 121) begin bad++; $display("FAIL avg_done_cycle got=%0d want=121", d); end
        total++; if (ncal !== 6'd37 || pcal !== 6'd20) begin bad++; $display("FAIL avg_codes got=%0d/%0d want=37/20", ncal, pcal); end
    endtask
`endif

    initial begin
        start = 1'b0;
        abort = 1'b0;
        settle = 8'd4;
        test_reset();
        test_basic();
        test_settle_zero();
        test_saturation();
        test_abort();
        test_start_ignored();
        test_reset_mid();
`ifdef DDR_ZQCAL_AVG_EN
        test_avg_glitch();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ddr_zqcal_ctrl.md
# ddr_zqcal_ctrl

Digital ZQ calibration controller that drives the common block's ZQCAL analog controls (cal enable, pull-down select, NCAL/PCAL codes) and reads back its comparator output. On a start request it runs a successive-approximation (SAR) search: first the pull-down NCAL code against the external resistor, then the pull-up PCAL code. It then holds the resulting codes for the DQ/CA drivers. It sits in the CMN digital domain, between the CSR/sequencer and the CMN analog wrapper's `i_cmn_zqcal_cfg` fields and `o_zqcal_comp`.

## Interface
- CODE_W, 6, width of NCAL and PCAL codes
- CNT_W, 8, width of settle counter
- i_clk  in  1  CMN digital clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_start  in  1  single-cycle start pulse; ignored unless IDLE
- i_abort  in  1  abandon calibration; effective any non-IDLE state
- i_settle_cnt  in  CNT_W  extra settle cycles per SAR trial
- i_zqcal_comp  in  1  analog comparator, asynchronous; 1 = trial code ≤ target (keep bit)
- o_cal_ena  out  1  ZQCAL cal enable
- o_pd_sel  out  1  1 = pull-down (NCAL) phase
- o_ncal  out  CODE_W  NCAL code to analog
- o_pcal  out  CODE_W  PCAL code to analog
- o_busy  out  1  calibration in progress
- o_done  out  1  one-cycle pulse on successful completion
- o_sat  out  2  [0] NCAL result all-0/all-1, [1] PCAL result all-0/all-1; sticky until next start

## Operation
- Reset: all outputs 0, result registers 0, state IDLE.
- States: IDLE, PD_SET, PD_WAIT, PD_SAMP, PU_SET, PU_WAIT, PU_SAMP, DONE.
- IDLE + i_start → PD_SET. Bit index = CODE_W-1. Trial = 0. o_sat is cleared.
- *_SET (1 cycle): sets trial[bit] = 1.
- *_WAIT: lasts i_settle_cnt+2 cycles. The extra 2 cover the synchronizer delay.
- *_SAMP (1 cycle): sync comp = 0 clears trial[bit]. Then:
  - If bit > 0: decrement bit and go to *_SET.
  - Else in PD: store trial into the NCAL result register and go to PU_SET with bit = CODE_W-1, trial = 0.
  - Else in PU: store trial into the PCAL result register and go to DONE.
- DONE (1 cycle): o_done = 1. Sets o_sat. Next state IDLE.
- Output muxing:
  - o_cal_ena = 1 in every state except IDLE.
  - o_pd_sel = 1 in PD_* states only.
  - o_ncal = trial during PD_*, else NCAL result.
  - o_pcal = trial during PU_*, else PCAL result.
- Abort: any non-IDLE state goes to IDLE next cycle. Results keep their prior completed values (a completed NCAL from the current run is kept). No o_done, o_sat unchanged.
- Abort and start in the same cycle: abort wins. i_start in non-IDLE is ignored.
- i_settle_cnt is sampled at each *_WAIT entry. A change mid-run takes effect on the next trial.
- i_zqcal_comp passes through a 2-flop synchronizer before use. Only the synchronized value is sampled.

## Timing
- o_busy/o_cal_ena rise 1 cycle after the i_start edge.
- Per-bit cost = S+4 cycles (S = i_settle_cnt): SET 1 + WAIT S+2 + SAMP 1. With DDR_ZQCAL_AVG_EN, SAMP is 3 cycles, giving S+6.
- o_done is high 2·CODE_W·(S+4)+1 cycles after the i_start edge.
- o_busy falls together with the o_done cycle's exit. o_busy is 0 in the cycle after DONE.
- Result registers update at the final SAMP of each phase.
- Codes change only at SET or SAMP edges. They are glitch-free, registered outputs.

## Configuration
- DDR_ZQCAL_AVG_EN defined: each SAMP state takes 3 consecutive synchronized samples. The bit decision is the majority of the 3. Adds a 2-bit vote counter.
- Undefined: single sample, 1-cycle SAMP.

## Structure
- Package ddr_zqcal_pkg holds:
  - state enum zqcal_state_t
  - sync depth constant ZQCAL_SYNC_STAGES = 2
  - phase enum (PD/PU)
- Sub-module ddr_zqcal_sar is one SAR engine (trial register, bit index, keep/clear, last-bit flag). It is reused for both phases and cleared at phase entry.
- The synchronizer uses the codebase's standard 2-flop demet cell.

## Test plan
Bench model: comp = (code ≤ target), driven asynchronously.
- Basic calibration:
  - Stimulus: reset, CODE_W=6, S=4, NCAL target 37, PCAL target 20, pulse i_start.
  - Response: o_ncal=37, o_pcal=20, o_done at cycle 97, o_sat=0, o_cal_ena back to 0.
- Saturation:
  - Stimulus: target 63 for NCAL, 0 for PCAL.
  - Response: o_ncal=63, o_pcal=0, o_sat=2'b11.
- Abort:
  - Stimulus: complete a run (37/20), then start with targets 10/50 and abort during PU phase bit 3.
  - Response: o_ncal=10, o_pcal=20, no o_done, o_busy=0 next cycle.
- Start ignored while busy:
  - Stimulus: i_start pulses at cycles 5 and 40 of a run.
  - Response: single o_done at 97, same results.
- Reset mid-run:
  - Stimulus: assert i_rst_n low during PD_WAIT.
  - Response: all outputs 0 immediately (async), state IDLE after release.
- DDR_ZQCAL_AVG_EN:
  - Stimulus: comp glitches low for one sample per bit at target 37, S=4.
  - Response: result still 37, o_done at cycle 2·6·10+1=121.
